fpu_mant_mul_seq: RTL and testbench

//   Iterative unsigned mantissa multiplier for the FPU multiply path. Inverse counterpart
//   of the restoring divide step: radix-2 shift-and-add, one multiplier bit per cycle.

---
 rtl/fpu_mant_mul_seq.sv | 95 +++++++++
 tb/tb_fpu_mant_mul_seq.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/fpu_mant_mul_seq.sv
// Radix-2 shift-and-add unsigned significand multiplier, one multiplier bit per cycle.
// Accept-to-result latency WIDTH cycles; result held in DONE until out_ready, no input taken while BUSY/DONE.
module fpu_mant_mul_seq #(
  parameter int WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_multiplicand,
  input  logic [WIDTH-1:0]     in_multiplier,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic                 out_busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     mplr_q, mplr_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH:0]       sum;
  logic [WIDTH-1:0]     acc_nxt;
  logic [WIDTH-1:0]     mplr_nxt;

  // Carry out of the add becomes the top bit of the shifted accumulator.
  always_comb begin
    sum      = {1'b0, acc_q} + (mplr_q[0] ? {1'b0, mcand_q} : '0);
    acc_nxt  = sum[WIDTH:1];
    mplr_nxt = {sum[0], mplr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mplr_d  = mplr_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mcand_d = in_multiplicand;
          mplr_d  = in_multiplier;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        acc_d  = acc_nxt;
        mplr_d = mplr_nxt;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          prod_d  = {acc_nxt, mplr_nxt};
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mplr_q  <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mplr_q  <= mplr_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign out_busy    = (state_q == BUSY);
  assign out_product = prod_q;

endmodule

// File: tb/tb_fpu_mant_mul_seq.sv
// Bench for fpu_mant_mul_seq: directed corner products plus random operands,
// checked against a plain arithmetic product and a fixed WIDTH-cycle latency.
module tb_fpu_mant_mul_seq;

  localparam int WIDTH = 24;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_multiplicand;
  logic [WIDTH-1:0]     in_multiplier;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   out_product;
  logic                 out_busy;

  int n_chk  = 0;
  int n_fail = 0;

  fpu_mant_mul_seq #(.WIDTH(WIDTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_multiplicand (in_multiplicand),
    .in_multiplier   (in_multiplier),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_product     (out_product),
    .out_busy        (out_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction: accept, wait for result, optional backpressure, release.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input int bp, input bit scramble);
    logic [2*WIDTH-1:0] expv;
    int  n;
    bit  seen;
    expv = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    chk("idle_in_ready", in_ready, 1);
    in_valid        = 1'b1;
    in_multiplicand = a;
    in_multiplier   = b;
    tick();
    chk("accept_busy", out_busy, 1);
    chk("accept_in_ready", in_ready, 0);
    in_valid = 1'b0;
    n    = 0;
    seen = 0;
    while (!seen && n < 60) begin
      if (scramble) begin
        in_valid        = 1'($urandom);
        in_multiplicand = WIDTH'($urandom);
        in_multiplier   = WIDTH'($urandom);
      end
      tick();
      n++;
      if (out_valid) seen = 1;
    end
    in_valid = 1'b0;
    chk("latency", n, WIDTH);
    chk("product", out_product, expv);
    for (int i = 0; i < bp; i++) begin
      in_valid        = 1'b1;
      in_multiplicand = WIDTH'($urandom);
      in_multiplier   = WIDTH'($urandom);
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_product", out_product, expv);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release_valid", out_valid, 0);
    chk("release_in_ready", in_ready, 1);
    chk("retain_product", out_product, expv);
  endtask

  initial begin
    rst             = 1'b1;
    in_valid        = 1'b0;
    out_ready       = 1'b0;
    in_multiplicand = '0;
    in_multiplier   = '0;
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", out_busy, 0);
    chk("rst_product", out_product, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", in_ready, 1);

    run_op(24'h800000, 24'h800000, 0, 0);
    run_op(24'hFFFFFF, 24'hFFFFFF, 0, 0);
    run_op(24'hC00000, 24'hC00000, 0, 0);
    run_op(24'h000000, 24'hABCDEF, 0, 0);
    run_op(24'h000001, 24'h000001, 5, 0);
    run_op(24'h123456, 24'h654321, 0, 1);

    // Abort part way through: reset at BUSY count=10 discards the result.
    in_valid        = 1'b1;
    in_multiplicand = 24'h123456;
    in_multiplier   = 24'h111111;
    tick();
    in_valid = 1'b0;
    repeat (10) tick();
    chk("pre_abort_busy", out_busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_valid", out_valid, 0);
    chk("abort_busy", out_busy, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_product", out_product, 0);
    tick();
    chk("abort_no_valid", out_valid, 0);
    run_op(24'h800001, 24'h000003, 0, 0);

    for (int k = 0; k < 20; k++) begin
      run_op(WIDTH'($urandom), WIDTH'($urandom), int'($urandom_range(0, 3)),
             1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
